// File: rtl/n4_b3_counter_ctrl_if.sv
// rtl/n4_b3_counter_ctrl_if.sv - host and counter-side signals of the base-3 counter sequencer
interface n4_b3_counter_ctrl_if;
    logic       soc;
    logic [7:0] target;
    logic [7:0] cnt_q;
    logic       cnt_eu;
    logic       eoc;
    logic       cnt_ei;
    logic       cnt_clr_;
    logic       err;
    logic       wrap;
    logic [6:0] steps;

    modport master (
        output soc, target, cnt_q, cnt_eu,
        input  eoc, cnt_ei, cnt_clr_, err, wrap, steps
    );

    modport slave (
        input  soc, target, cnt_q, cnt_eu,
        output eoc, cnt_ei, cnt_clr_, err, wrap, steps
    );
endinterface

// File: rtl/n4_b3_counter_ctrl.sv
// rtl/n4_b3_counter_ctrl.sv - clears a base-3 counter, then paces its enable until its digits reach a sampled target
module n4_b3_counter_ctrl #(
    parameter int PRESCALE = 4
) (
    input logic                  m_clock,
    input logic                  m_reset,
    n4_b3_counter_ctrl_if.slave  bus
);
    localparam logic [7:0] RELOAD = 8'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t     state;
    logic [7:0] pre;
    logic [7:0] tgt_q;
    logic       eoc;
    logic       clr_n;
    logic       err;
    logic       wrap;
    logic [6:0] steps;
    logic       ei;

    function automatic logic has_bad_digit(input logic [7:0] t);
        return (t[7:6] == 2'b11) || (t[5:4] == 2'b11) ||
               (t[3:2] == 2'b11) || (t[1:0] == 2'b11);
    endfunction

    // The counter's digits settle one edge after each pulse, so the compare only
    // runs on prescaler expiry, never on the cycle right after a pulse.
    always_comb begin
        ei = (state == RUN) && (pre == 8'd0) && (bus.cnt_q != tgt_q);
    end

    always_ff @(posedge m_clock or posedge m_reset) begin
        if (m_reset) begin
            state <= IDLE;
            eoc   <= 1'b1;
            clr_n <= 1'b1;
            err   <= 1'b0;
            wrap  <= 1'b0;
            steps <= 7'd0;
            pre   <= 8'd0;
            tgt_q <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.soc) begin
                        tgt_q <= bus.target;
                        eoc   <= 1'b0;
                        // The clear is only issued for targets the counter can reach.
                        clr_n <= has_bad_digit(bus.target);
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    clr_n <= 1'b1;
                    if (has_bad_digit(tgt_q)) begin
                        err   <= 1'b1;
                        eoc   <= 1'b1;
                        state <= DONE;
                    end else begin
                        err   <= 1'b0;
                        wrap  <= 1'b0;
                        steps <= 7'd0;
                        pre   <= RELOAD;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (pre == 8'd0) begin
                        if (bus.cnt_q == tgt_q) begin
                            eoc   <= 1'b1;
                            state <= DONE;
                        end else begin
                            steps <= steps + 7'd1;
                            pre   <= RELOAD;
                            if (bus.cnt_eu) begin
                                wrap <= 1'b1;
                            end
                        end
                    end else begin
                        pre <= pre - 8'd1;
                    end
                end
                DONE: begin
                    if (!bus.soc) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    eoc   <= 1'b1;
                    clr_n <= 1'b1;
                end
            endcase
        end
    end

    assign bus.eoc      = eoc;
    assign bus.cnt_ei   = ei;
    assign bus.cnt_clr_ = clr_n;
    assign bus.err      = err;
    assign bus.wrap     = wrap;
    assign bus.steps    = steps;
endmodule

// File: tb/tb_n4_b3_counter_ctrl.sv
// tb/tb_n4_b3_counter_ctrl.sv - self-checking bench for n4_b3_counter_ctrl with a behavioural base-3 counter
module tb_n4_b3_counter_ctrl;
    localparam int P = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   eu_force = 1'b0;
    int   val = 0;
    int   total = 0;
    int   bad = 0;
    int   m_steps = 0;
    bit   m_wrap = 1'b0;

    n4_b3_counter_ctrl_if bus();

    n4_b3_counter_ctrl #(.PRESCALE(P)) dut (
        .m_clock (clk),
        .m_reset (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Counter behaviour: a plain integer 0..80 shown as four base-3 digits.
    always @(posedge clk) begin
        if (!bus.cnt_clr_)
            val <= 0;
        else if (bus.cnt_ei)
            val <= (val + 1) % 81;
    end

    assign bus.cnt_q  = {2'(val / 27), 2'((val / 9) % 3), 2'((val / 3) % 3), 2'(val % 3)};
    assign bus.cnt_eu = (val == 80) || eu_force;

    typedef struct {
        logic [7:0] target;
        bit         drop_early;
        bit         force_eu;
        bit         exp_err;
        int         exp_steps;
        bit         exp_wrap;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit tgt_bad(input logic [7:0] t);
        logic [7:0] tt;
        tt = t;
        for (int i = 0; i < 4; i++)
            if (tt[2*i +: 2] == 2'b11) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int tgt_val(input logic [7:0] t);
        logic [7:0] tt;
        tt = t;
        return int'(tt[7:6]) * 27 + int'(tt[5:4]) * 9 + int'(tt[3:2]) * 3 + int'(tt[1:0]);
    endfunction

    task automatic do_run(input string tag, input logic [7:0] tgt, input bit drop_early,
                          input bit exp_err, input int exp_steps, input bit exp_wrap);
        int cyc, nei, nclr, exp_lat;
        bit ei_ok, clr_ok;
        cyc = 0; nei = 0; nclr = 0; ei_ok = 1'b1; clr_ok = 1'b1;
        exp_lat = exp_err ? 1 : 1 + (exp_steps + 1) * P;
        @(posedge clk); #1;
        bus.target = tgt;
        bus.soc    = 1'b1;
        @(posedge clk); #1;
        while (bus.eoc == 1'b0 && cyc < 1000) begin
            if (bus.cnt_ei) begin
                nei++;
                if (cyc != P * nei) ei_ok = 1'b0;
            end
            if (!bus.cnt_clr_) begin
                nclr++;
                if (cyc != 0) clr_ok = 1'b0;
            end
            if (drop_early && cyc == 2) bus.soc = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " latency"}, cyc, exp_lat);
        chk({tag, " ei_count"}, nei, exp_err ? 0 : exp_steps);
        chk({tag, " ei_spacing"}, int'(ei_ok), 1);
        chk({tag, " clr_count"}, nclr, exp_err ? 0 : 1);
        chk({tag, " clr_timing"}, int'(clr_ok), 1);
        chk({tag, " err"}, int'(bus.err), int'(exp_err));
        chk({tag, " wrap"}, int'(bus.wrap), int'(exp_wrap));
        chk({tag, " steps"}, int'(bus.steps), exp_steps);
        if (!exp_err) chk({tag, " cnt_q"}, int'(bus.cnt_q), int'(tgt));
        if (!drop_early) begin
            for (int i = 0; i < 2; i++) begin
                @(posedge clk); #1;
                chk({tag, " done_hold"}, int'({bus.eoc, bus.cnt_clr_, bus.cnt_ei}), 3'b110);
            end
            bus.soc = 1'b0;
        end
        @(posedge clk); #1;
        chk({tag, " idle"}, int'({bus.eoc, bus.cnt_ei, bus.steps}), int'({1'b1, 1'b0, 7'(exp_steps)}));
        m_steps = exp_steps;
        m_wrap  = exp_wrap;
    endtask

    vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int nei, cyc;
        logic [7:0] t;
        vecs[0] = '{8'h00,         1'b0, 1'b0, 1'b0, 0,  1'b0};
        vecs[1] = '{8'b00_00_01_10, 1'b0, 1'b0, 1'b0, 5,  1'b0};
        vecs[2] = '{8'b00_11_00_00, 1'b0, 1'b0, 1'b1, 5,  1'b0};
        vecs[3] = '{8'b00_00_00_01, 1'b1, 1'b0, 1'b0, 1,  1'b0};
        vecs[4] = '{8'b10_10_10_10, 1'b0, 1'b0, 1'b0, 80, 1'b0};
        vecs[5] = '{8'b00_00_00_11, 1'b0, 1'b0, 1'b1, 80, 1'b0};
        vecs[6] = '{8'b00_00_00_10, 1'b0, 1'b1, 1'b0, 2,  1'b1};
        vecs[7] = '{8'b11_00_00_00, 1'b0, 1'b0, 1'b1, 2,  1'b1};
        vecs[8] = '{8'b01_00_00_00, 1'b0, 1'b0, 1'b0, 27, 1'b0};

        bus.soc = 1'b0;
        bus.target = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", int'({bus.eoc, bus.cnt_ei, bus.cnt_clr_, bus.err, bus.wrap, bus.steps}),
            int'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0}));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle no soc", int'({bus.eoc, bus.cnt_ei, bus.cnt_clr_}), 3'b101);

        for (int i = 0; i < 9; i++) begin
            eu_force = vecs[i].force_eu;
            do_run($sformatf("vec%0d", i), vecs[i].target, vecs[i].drop_early,
                   vecs[i].exp_err, vecs[i].exp_steps, vecs[i].exp_wrap);
        end
        eu_force = 1'b0;

        // Reset in the middle of a run, after the third pulse.
        @(posedge clk); #1;
        bus.target = 8'b00_00_01_10;
        bus.soc = 1'b1;
        nei = 0; cyc = 0;
        while (nei < 3 && cyc < 100) begin
            @(posedge clk); #1;
            if (bus.cnt_ei) nei++;
            cyc++;
        end
        chk("midrst pulses", nei, 3);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.soc = 1'b0;
        #1;
        chk("midrst outputs", int'({bus.eoc, bus.cnt_ei, bus.cnt_clr_, bus.err, bus.wrap, bus.steps}),
            int'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0}));
        chk("midrst counter kept", val, 3);
        #3;
        rst = 1'b0;
        do_run("after_rst", 8'b00_01_00_10, 1'b0, 1'b0, 11, 1'b0);

        // Random targets against the arithmetic model.
        for (int r = 0; r < 16; r++) begin
            t = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
            if ($urandom_range(0, 4) == 0) t[2*$urandom_range(0, 3) +: 2] = 2'b11;
            if (tgt_bad(t))
                do_run($sformatf("rnd%0d", r), t, 1'b0, 1'b1, m_steps, m_wrap);
            else
                do_run($sformatf("rnd%0d", r), t, ($urandom_range(0, 1) == 1), 1'b0, tgt_val(t), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
